pipelined_multiplier: RTL and testbench

PIPELINED_MULTIPLIER -- requirements
Module: pipelined_multiplier

---
 rtl/pipelined_multiplier.sv | 141 ++++++++++++++
 tb/tb_pipelined_multiplier.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_multiplier.sv
// Pipelined signed/unsigned multiplier with optional accumulate and
// ready/valid flow control on both sides; the output stage owns the accumulator.
module pipelined_multiplier #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2,
    parameter int GUARD  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       signed_mode,
    input  logic                       acc_en,
    input  logic                       acc_clr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*WIDTH+GUARD-1:0]   p
);

    localparam int RW = 2*WIDTH + GUARD;

    // Exact product of two WIDTH-bit operands, extended to the result width.
    function automatic logic [RW-1:0] ext_product(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic             sgn
    );
        logic [2*WIDTH-1:0] xe;
        logic [2*WIDTH-1:0] ye;
        logic [2*WIDTH-1:0] pr;
        xe = sgn ? {{WIDTH{x[WIDTH-1]}}, x} : {{WIDTH{1'b0}}, x};
        ye = sgn ? {{WIDTH{y[WIDTH-1]}}, y} : {{WIDTH{1'b0}}, y};
        pr = xe * ye;
        return sgn ? RW'($signed(pr)) : RW'(pr);
    endfunction

    logic            adv_s;
    logic [RW-1:0]   prod_in_s;
    logic            last_vld_s;
    logic [RW-1:0]   last_prod_s;
    logic            last_acc_en_s;
    logic            last_clr_s;

    logic            out_valid_q;
    logic            out_valid_d;
    logic [RW-1:0]   p_q;
    logic [RW-1:0]   p_d;
    logic [RW-1:0]   acc_q;
    logic [RW-1:0]   acc_d;

    assign adv_s     = !out_valid_q || out_ready;
    assign in_ready  = adv_s;
    assign prod_in_s = ext_product(a, b, signed_mode);

    generate
        if (STAGES > 1) begin : g_pipe
            logic            vld_q    [STAGES-1];
            logic [RW-1:0]   prod_q   [STAGES-1];
            logic            acc_en_q [STAGES-1];
            logic            clr_q    [STAGES-1];

            // Product stages ahead of the output stage; payload moves only with a valid beat.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGES-1; i++) begin
                        vld_q[i]    <= 1'b0;
                        prod_q[i]   <= '0;
                        acc_en_q[i] <= 1'b0;
                        clr_q[i]    <= 1'b0;
                    end
                end else if (adv_s) begin
                    vld_q[0] <= in_valid;
                    if (in_valid) begin
                        prod_q[0]   <= prod_in_s;
                        acc_en_q[0] <= acc_en;
                        clr_q[0]    <= acc_clr;
                    end
                    for (int i = 1; i < STAGES-1; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        if (vld_q[i-1]) begin
                            prod_q[i]   <= prod_q[i-1];
                            acc_en_q[i] <= acc_en_q[i-1];
                            clr_q[i]    <= clr_q[i-1];
                        end
                    end
                end
            end

            assign last_vld_s    = vld_q[STAGES-2];
            assign last_prod_s   = prod_q[STAGES-2];
            assign last_acc_en_s = acc_en_q[STAGES-2];
            assign last_clr_s    = clr_q[STAGES-2];
        end else begin : g_direct
            assign last_vld_s    = in_valid;
            assign last_prod_s   = prod_in_s;
            assign last_acc_en_s = acc_en;
            assign last_clr_s    = acc_clr;
        end
    endgenerate

    // Output stage next state: accumulator moves only when a beat lands here.
    always_comb begin
        out_valid_d = out_valid_q;
        p_d         = p_q;
        acc_d       = acc_q;
        if (adv_s) begin
            out_valid_d = last_vld_s;
            if (last_vld_s) begin
                if (last_acc_en_s) begin
                    acc_d = (last_clr_s ? {RW{1'b0}} : acc_q) + last_prod_s;
                    p_d   = acc_d;
                end else begin
                    p_d = last_prod_s;
                end
            end else begin
                p_d = p_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output stage and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            p_q         <= '0;
            acc_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            p_q         <= p_d;
            acc_q       <= acc_d;
        end
    end

    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule

// File: tb/tb_pipelined_multiplier.sv
// Directed bench for pipelined_multiplier: scoreboard model of the result
// stream plus literal checks of known products and accumulations.
module tb_pipelined_multiplier;

    localparam int W  = 16;
    localparam int S  = 2;
    localparam int G  = 8;
    localparam int RW = 2*W + G;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, signed_mode, acc_en, acc_clr;
    logic          out_valid, out_ready;
    logic [W-1:0]  a, b;
    logic [RW-1:0] p;

    logic          w_valid, w_ready, w_sgn, w_en, w_clr, w_ovalid, w_oready;
    logic [3:0]    w_a, w_b;
    logic [7:0]    w_p;

    int nchk = 0;
    int nfail = 0;

    logic [RW-1:0] exp_q [$];
    logic [RW-1:0] got_q [$];
    logic [RW-1:0] m_acc;

    always #5 clk = ~clk;

    pipelined_multiplier #(.WIDTH(W), .STAGES(S), .GUARD(G)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .p(p)
    );

    pipelined_multiplier #(.WIDTH(4), .STAGES(2), .GUARD(0)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_valid), .in_ready(w_ready),
        .a(w_a), .b(w_b), .signed_mode(w_sgn), .acc_en(w_en), .acc_clr(w_clr),
        .out_valid(w_ovalid), .out_ready(w_oready), .p(w_p)
    );

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        nchk++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [RW-1:0] model_prod(input logic [W-1:0] x, input logic [W-1:0] y, input logic sgn);
        longint r;
        if (sgn) r = longint'($signed(x)) * longint'($signed(y));
        else     r = longint'({1'b0, x}) * longint'({1'b0, y});
        return r[RW-1:0];
    endfunction

    // Scoreboard: expected results queued in acceptance order, checked at each output handshake.
    initial begin
        logic          stalled_prev;
        logic [RW-1:0] p_prev;
        logic [RW-1:0] e;
        stalled_prev = 1'b0;
        p_prev = '0;
        m_acc = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
                m_acc = '0;
                stalled_prev = 1'b0;
            end else begin
                chk(in_ready == !(out_valid && !out_ready), "in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
                if (stalled_prev) begin
                    chk(out_valid == 1'b1, "stall_valid_hold", 64'(out_valid), 64'd1);
                    chk(p == p_prev, "stall_p_hold", 64'(p), 64'(p_prev));
                end
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk(1'b0, "spurious_out_valid", 64'(p), 64'd0);
                    end else if (out_ready) begin
                        chk(p == exp_q[0], "stream_p", 64'(p), 64'(exp_q[0]));
                        got_q.push_back(p);
                        void'(exp_q.pop_front());
                    end
                end
                if (in_valid && in_ready) begin
                    e = model_prod(a, b, signed_mode);
                    if (acc_en) begin
                        m_acc = (acc_clr ? '0 : m_acc) + e;
                        e = m_acc;
                    end
                    exp_q.push_back(e);
                end
                stalled_prev = out_valid && !out_ready;
                p_prev = p;
            end
        end
    end

    task automatic idle_inputs();
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        signed_mode = 1'($urandom);
        acc_en = 1'($urandom);
        acc_clr = 1'($urandom);
    endtask

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts, input logic te, input logic tc);
        bit took;
        int n;
        a = ta; b = tb; signed_mode = ts; acc_en = te; acc_clr = tc; in_valid = 1'b1;
        took = 1'b0;
        n = 0;
        while (!took && n < 100) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!took) chk(1'b0, "send_timeout", 64'(n), 64'd100);
        idle_inputs();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(exp_q.size() == 0, "drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base;
        int n;
        logic [3:0] pat;
        rst_n = 1'b0;
        out_ready = 1'b1;
        idle_inputs();
        w_valid = 1'b0; w_a = 4'd0; w_b = 4'd0; w_sgn = 1'b0; w_en = 1'b0; w_clr = 1'b0; w_oready = 1'b1;

        #1;
        chk(in_ready == 1'b1, "reset_in_ready", 64'(in_ready), 64'd1);
        chk(out_valid == 1'b0, "reset_out_valid", 64'(out_valid), 64'd0);
        chk(p == '0, "reset_p", 64'(p), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk(in_ready == 1'b1, "post_reset_in_ready", 64'(in_ready), 64'd1);

        // Wrap-around on the narrow instance: 225, then 450 mod 256.
        w_valid = 1'b1; w_a = 4'd15; w_b = 4'd15; w_en = 1'b1; w_clr = 1'b1;
        @(posedge clk); #1;
        w_clr = 1'b0;
        @(posedge clk); #1;
        w_valid = 1'b0;
        chk(w_ovalid == 1'b1, "wrap_valid1", 64'(w_ovalid), 64'd1);
        chk(w_p == 8'd225, "wrap_p1", 64'(w_p), 64'd225);
        @(posedge clk); #1;
        chk(w_ovalid == 1'b1, "wrap_valid2", 64'(w_ovalid), 64'd1);
        chk(w_p == 8'd194, "wrap_p2", 64'(w_p), 64'd194);

        // Latency and full-scale unsigned product.
        send(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        repeat (S-2) @(posedge clk);
        chk(out_valid == 1'b0, "latency_early", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        chk(out_valid == 1'b1, "latency_valid", 64'(out_valid), 64'd1);
        chk(p == 40'h00_FFFE_0001, "p_ffff_sq", 64'(p), 64'h00FFFE0001);
        drain();

        // Signed vs unsigned interpretation of the same operands.
        base = got_q.size();
        send(16'hFFFF, 16'h0003, 1'b1, 1'b0, 1'b0);
        send(16'hFFFF, 16'h0003, 1'b0, 1'b0, 1'b0);
        drain();
        chk(got_q[base] == 40'hFF_FFFF_FFFD, "signed_m1x3", 64'(got_q[base]), 64'hFFFFFFFFFD);
        chk(got_q[base+1] == 40'h00_0002_FFFD, "unsigned_ffffx3", 64'(got_q[base+1]), 64'h000002FFFD);

        // Back-to-back accumulate chain with a pass-through beat in the middle.
        base = got_q.size();
        send(16'd2, 16'd3, 1'b0, 1'b1, 1'b1);
        send(16'd4, 16'd5, 1'b0, 1'b1, 1'b0);
        send(16'hFFFF, 16'd1, 1'b1, 1'b1, 1'b0);
        send(16'd7, 16'd7, 1'b0, 1'b0, 1'b0);
        send(16'd1, 16'd1, 1'b0, 1'b1, 1'b0);
        drain();
        chk(got_q[base] == 40'd6, "acc_6", 64'(got_q[base]), 64'd6);
        chk(got_q[base+1] == 40'd26, "acc_26", 64'(got_q[base+1]), 64'd26);
        chk(got_q[base+2] == 40'd25, "acc_25", 64'(got_q[base+2]), 64'd25);
        chk(got_q[base+3] == 40'd49, "noacc_49", 64'(got_q[base+3]), 64'd49);
        chk(got_q[base+4] == 40'd26, "acc_26b", 64'(got_q[base+4]), 64'd26);

        // Backpressure: out_ready follows 1,0,0,1 while 8 beats stream in.
        base = got_q.size();
        pat = 4'b1001;
        fork
            begin
                for (int i = 0; i < 8; i++) send(16'(i + 1), 16'd100, 1'b0, 1'b0, 1'b0);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    out_ready = pat[k % 4];
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        chk(got_q.size() == base + 8, "bp_count", 64'(got_q.size() - base), 64'd8);
        for (int i = 0; i < 8 && base + i < got_q.size(); i++)
            chk(got_q[base+i] == 40'((i + 1) * 100), "bp_order", 64'(got_q[base+i]), 64'((i + 1) * 100));

        // Reset while a result is stalled; accumulator restarts from zero.
        out_ready = 1'b0;
        send(16'd3, 16'd3, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk(out_valid == 1'b1, "stall_before_reset", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk(out_valid == 1'b0, "rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk(p == '0, "rst_mid_p", 64'(p), 64'd0);
        chk(in_ready == 1'b1, "rst_mid_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk(out_valid == 1'b0, "no_valid_after_reset", 64'(out_valid), 64'd0);
        end
        base = got_q.size();
        send(16'd2, 16'd2, 1'b0, 1'b1, 1'b0);
        drain();
        chk(got_q.size() > base && got_q[base] == 40'd4, "acc_after_reset", 64'(got_q.size() > base ? got_q[base] : '0), 64'd4);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
